// File: rtl/sts_tx_generator.sv
// sts_tx_generator: streams the 802.11a short training sequence as PHASES parallel I/Q samples per beat
module sts_tx_generator #(
    parameter int DATAWIDTH   = 16,
    parameter int PHASES      = 16,
    parameter int PERIODICITY = 16,
    parameter int NREP        = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic [1:0]                  scale_i,
    input  logic                        out_ready_i,
    output logic                        out_valid_o,
    output logic signed [DATAWIDTH-1:0] i_out_o [0:PHASES-1],
    output logic signed [DATAWIDTH-1:0] q_out_o [0:PHASES-1],
    output logic                        last_o,
    output logic                        busy_o,
    output logic                        done_o
);
    localparam int NBEATS = NREP * PERIODICITY / PHASES;
    localparam int BW = $clog2(NBEATS + 1);
    localparam int PW = PERIODICITY > 1 ? $clog2(PERIODICITY) : 1;
    localparam logic signed [15:0] ROM_I [16] = '{
        16'sd1507, -16'sd4325, -16'sd426, 16'sd4686, 16'sd3015, 16'sd4686, -16'sd426, -16'sd4325,
        16'sd1507, 16'sd66, -16'sd2589, -16'sd426, 16'sd0, -16'sd426, -16'sd2589, 16'sd66};
    localparam logic signed [15:0] ROM_Q [16] = '{
        16'sd1507, 16'sd66, -16'sd2589, -16'sd426, 16'sd0, -16'sd426, -16'sd2589, 16'sd66,
        16'sd1507, -16'sd4325, -16'sd426, 16'sd4686, 16'sd3015, 16'sd4686, -16'sd426, -16'sd4325};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                      state;
    logic [BW-1:0]               beat;
    logic [PW-1:0]               phase;
    logic [PW-1:0]               ld_phase;
    logic [1:0]                  scale;
    logic [1:0]                  ld_scale;
    logic signed [DATAWIDTH-1:0] ld_i [0:PHASES-1];
    logic signed [DATAWIDTH-1:0] ld_q [0:PHASES-1];

    // samples of the beat to load next: phase 0 with the live scale on start, else the following phase
    always_comb begin
        ld_phase = state == IDLE ? '0 : PW'((32'(phase) + PHASES) % PERIODICITY);
        ld_scale = state == IDLE ? scale_i : scale;
        for (int p = 0; p < PHASES; p++) begin
            ld_i[p] = DATAWIDTH'(ROM_I[4'((32'(ld_phase) + p) % 16)] >>> ld_scale);
            ld_q[p] = DATAWIDTH'(ROM_Q[4'((32'(ld_phase) + p) % 16)] >>> ld_scale);
        end
    end

    // burst sequencer with every output registered; abort wins over start and over the final transfer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            beat        <= '0;
            phase       <= '0;
            scale       <= '0;
            out_valid_o <= 1'b0;
            last_o      <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            i_out_o     <= '{default: '0};
            q_out_o     <= '{default: '0};
        end else begin
            case (state)
                IDLE: if (start_i && !abort_i) begin
                    state       <= RUN;
                    scale       <= scale_i;
                    beat        <= '0;
                    phase       <= '0;
                    out_valid_o <= 1'b1;
                    busy_o      <= 1'b1;
                    last_o      <= NBEATS == 1;
                    i_out_o     <= ld_i;
                    q_out_o     <= ld_q;
                end
                RUN: if (abort_i || (out_ready_i && last_o)) begin
                    state       <= abort_i ? IDLE : FLUSH;
                    done_o      <= !abort_i;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    last_o      <= 1'b0;
                    i_out_o     <= '{default: '0};
                    q_out_o     <= '{default: '0};
                end else if (out_ready_i) begin
                    beat        <= beat + 1'b1;
                    phase       <= ld_phase;
                    last_o      <= 32'(beat) + 2 == NBEATS;
                    i_out_o     <= ld_i;
                    q_out_o     <= ld_q;
                end
                default: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
